isa_cycle_sequencer: RTL and testbench

ISA_CYCLE_SEQUENCER -- requirements
Module: isa_cycle_sequencer

---
 rtl/isa_seq_pkg.sv | 17 +
 rtl/bit_synchronizer.sv | 18 +
 rtl/isa_cycle_sequencer.sv | 175 +++++++++++++++++
 tb/tb_isa_cycle_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/isa_seq_pkg.sv
// Shared state encoding and default bus timing for the ISA I/O cycle sequencer.
package isa_seq_pkg;

  localparam int DEF_SETUP_CYCLES   = 4;
  localparam int DEF_STROBE_CYCLES  = 12;
  localparam int DEF_HOLD_CYCLES    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, STROBE, WAIT_RDY, CAPTURE, HOLD, DONE
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchroniser for a single asynchronous level input.
module bit_synchronizer (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/isa_cycle_sequencer.sv
// Sequences one ISA I/O read or write: setup, strobe, iochrdy wait with timeout, hold.
module isa_cycle_sequencer
  import isa_seq_pkg::*;
#(
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_address,
  input  logic [15:0] cmd_data,
  input  logic        iochrdy,
  output logic [15:0] address_HPS,
  output logic [15:0] data_HPS,
  output logic        address_load,
  output logic        data_load,
  output logic        data_read,
  output logic        data_write,
  output logic        iow,
  output logic        ior,
  output logic        rsp_valid,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int MAX_CYC = max2(max2(SETUP_CYCLES, STROBE_CYCLES),
                                max2(HOLD_CYCLES, TIMEOUT_CYCLES));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Counter is loaded with N-1 on entry so a state lasts N cycles ending at zero.
  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic             flag_q, flag_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic             rdy_sync;

  logic iow_q, ior_q, dw_q, al_q, dl_q, dr_q, rv_q, rt_q;
  logic iow_d, ior_d, dw_d, al_d, dl_d, dr_d, rv_d, rt_d;

  bit_synchronizer u_rdy_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (iochrdy),
    .q_o   (rdy_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    write_d = write_q;
    flag_d  = flag_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          state_d = LOAD;
          write_d = cmd_write;
          addr_d  = cmd_address;
          data_d  = cmd_data;
          flag_d  = 1'b0;
        end
      end
      LOAD: begin
        state_d = SETUP;
        cnt_d   = SETUP_LD;
      end
      SETUP: if (cnt_q == '0) begin
        state_d = STROBE;
        cnt_d   = STROBE_LD;
      end
      STROBE, WAIT_RDY: begin
        if ((state_q == WAIT_RDY || cnt_q == '0) && rdy_sync) begin
          state_d = write_q ? HOLD : CAPTURE;
          cnt_d   = write_q ? HOLD_LD : '0;
        end else if (cnt_q == '0 && state_q == STROBE) begin
          state_d = WAIT_RDY;
          cnt_d   = TIMEOUT_LD;
        end else if (cnt_q == '0) begin
          // Timed out: abandon the cycle, reads never capture.
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          flag_d  = 1'b1;
        end
      end
      CAPTURE: begin
        state_d = HOLD;
        cnt_d   = HOLD_LD;
      end
      HOLD: if (cnt_q == '0) begin
        state_d = DONE;
        cnt_d   = '0;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from next state and registered so they track state with no glitches.
  always_comb begin
    iow_d = !((state_d == STROBE || state_d == WAIT_RDY) && write_d);
    ior_d = !((state_d == STROBE || state_d == WAIT_RDY || state_d == CAPTURE) && !write_d);
    dw_d  = !(write_d && (state_d == SETUP || state_d == STROBE || state_d == WAIT_RDY ||
                          state_d == CAPTURE || state_d == HOLD));
    al_d  = (state_d == LOAD);
    dl_d  = (state_d == LOAD) && write_d;
    dr_d  = (state_d == CAPTURE);
    rv_d  = (state_d == DONE);
    rt_d  = (state_d == DONE) && flag_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      flag_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      iow_q   <= 1'b1;
      ior_q   <= 1'b1;
      dw_q    <= 1'b1;
      al_q    <= 1'b0;
      dl_q    <= 1'b0;
      dr_q    <= 1'b0;
      rv_q    <= 1'b0;
      rt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      flag_q  <= (state_d == IDLE) ? 1'b0 : flag_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      iow_q   <= iow_d;
      ior_q   <= ior_d;
      dw_q    <= dw_d;
      al_q    <= al_d;
      dl_q    <= dl_d;
      dr_q    <= dr_d;
      rv_q    <= rv_d;
      rt_q    <= rt_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign address_HPS  = addr_q;
  assign data_HPS     = data_q;
  assign iow          = iow_q;
  assign ior          = ior_q;
  assign data_write   = dw_q;
  assign address_load = al_q;
  assign data_load    = dl_q;
  assign data_read    = dr_q;
  assign rsp_valid    = rv_q;
  assign rsp_timeout  = rt_q;

endmodule

// File: tb/tb_isa_cycle_sequencer.sv
// Random and directed ISA cycles scored against a timing model derived from cycle arithmetic.
module tb_isa_cycle_sequencer;

  localparam int SETUP   = 4;
  localparam int STROBE  = 12;
  localparam int HOLDC   = 4;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_address = '0;
  logic [15:0] cmd_data = '0;
  logic        iochrdy = 1'b1;
  logic [15:0] address_HPS, data_HPS;
  logic        address_load, data_load, data_read, data_write;
  logic        iow, ior, rsp_valid, rsp_timeout, busy;

  isa_cycle_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_data(cmd_data),
    .iochrdy(iochrdy), .address_HPS(address_HPS), .data_HPS(data_HPS),
    .address_load(address_load), .data_load(data_load), .data_read(data_read),
    .data_write(data_write), .iow(iow), .ior(ior), .rsp_valid(rsp_valid),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rsp_cyc;
    bit          to;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          iow_lo;
    int          ior_lo;
    int          drd;
    int          dw_lo;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: mode 0 = ready throughout, 1 = ready rises at cycle a+d, 2 = never ready.
  function automatic exp_t model(input bit wr, input int mode, input int d, input int a,
                                 input logic [15:0] ad, input logic [15:0] dt);
    exp_t e;
    int first_lo, min_last, sync_hi, last, hs, lo;
    bit cap;
    first_lo = a + 2 + SETUP;
    min_last = a + 1 + SETUP + STROBE;
    sync_hi  = (mode == 0) ? -1 : (mode == 1) ? a + d + 2 : 32'h7fff_ffff;
    e.to     = (sync_hi > min_last + TIMEOUT);
    last     = e.to ? min_last + TIMEOUT : ((sync_hi > min_last) ? sync_hi : min_last);
    cap      = !wr && !e.to;
    hs       = last + 1 + (cap ? 1 : 0);
    e.rsp_cyc = hs + HOLDC;
    lo       = last - first_lo + 1 + (cap ? 1 : 0);
    e.wr     = wr;
    e.addr   = ad;
    e.data   = dt;
    e.iow_lo = wr ? lo : 0;
    e.ior_lo = wr ? 0 : lo;
    e.drd    = cap ? 1 : 0;
    e.dw_lo  = wr ? e.rsp_cyc - a - 2 : 0;
    return e;
  endfunction

  int c_iow = 0, c_ior = 0, c_dr = 0, c_dw = 0, c_al = 0, c_dl = 0;
  bit overlap = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      c_iow = 0; c_ior = 0; c_dr = 0; c_dw = 0; c_al = 0; c_dl = 0; overlap = 0;
    end else begin
      if (!iow) c_iow++;
      if (!ior) c_ior++;
      if (!iow && !ior) overlap = 1;
      if (data_read) c_dr++;
      if (!data_write) c_dw++;
      if (address_load) c_al++;
      if (data_load) c_dl++;
      if (rsp_valid) begin
        if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_cycle", cyc, e.rsp_cyc);
          chk("rsp_timeout", rsp_timeout, e.to);
          chk("address_HPS", address_HPS, e.addr);
          if (e.wr) chk("data_HPS", data_HPS, e.data);
          chk("iow_low_cycles", c_iow, e.iow_lo);
          chk("ior_low_cycles", c_ior, e.ior_lo);
          chk("data_read_pulses", c_dr, e.drd);
          chk("data_write_low_cycles", c_dw, e.dw_lo);
          chk("address_load_pulses", c_al, 1);
          chk("data_load_pulses", c_dl, e.wr ? 1 : 0);
          chk("strobe_overlap", overlap, 0);
        end
        c_iow = 0; c_ior = 0; c_dr = 0; c_dw = 0; c_al = 0; c_dl = 0; overlap = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 0, 1);
  endtask

  task automatic run_txn(input bit wr, input logic [15:0] ad, input logic [15:0] dt,
                         input int mode, input int d);
    int a, k;
    wait_ready();
    cmd_write   = wr;
    cmd_address = ad;
    cmd_data    = dt;
    cmd_valid   = 1'b1;
    a = cyc;
    if (mode != 0) iochrdy = 1'b0;
    sb.push_back(model(wr, mode, d, a, ad, dt));
    // Keep a changing command asserted while busy; it must not be re-accepted.
    k = $urandom_range(0, 10);
    forever begin
      @(negedge clk);
      if (cyc - a <= k) begin
        cmd_write   = $urandom_range(0, 1);
        cmd_address = 16'($urandom);
        cmd_data    = 16'($urandom);
      end else cmd_valid = 1'b0;
      if (mode == 1 && cyc >= a + d) iochrdy = 1'b1;
      if (cyc - a > k && (mode != 1 || cyc >= a + d)) break;
    end
    wait_ready();
    iochrdy = 1'b1;
    repeat ($urandom_range(2, 4)) @(negedge clk);
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a, sel;
    repeat (3) @(negedge clk);
    chk("reset_iow", iow, 1);
    chk("reset_ior", ior, 1);
    chk("reset_data_write", data_write, 1);
    chk("reset_pulses", {address_load, data_load, data_read, rsp_valid, rsp_timeout}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_address_HPS", address_HPS, 0);
    chk("reset_data_HPS", data_HPS, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_txn(1, 16'h0220, 16'hA5A5, 0, 0);
    run_txn(0, 16'h0388, 16'h0000, 0, 0);
    run_txn(1, 16'h0300, 16'h1234, 1, 40);
    run_txn(0, 16'h0301, 16'h0000, 2, 0);
    run_txn(1, 16'h0302, 16'h5555, 1, 1 + SETUP + STROBE + TIMEOUT - 2);
    run_txn(0, 16'h0303, 16'h0000, 1, 1 + SETUP + STROBE + TIMEOUT - 1);
    run_txn(0, 16'h0304, 16'h0000, 1, 15);
    run_txn(1, 16'h0305, 16'hAAAA, 1, 16);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      run_txn($urandom_range(0, 1), 16'($urandom), 16'($urandom), 0, 0);
      else if (sel < 7) run_txn($urandom_range(0, 1), 16'($urandom), 16'($urandom), 1,
                                $urandom_range(1, 14));
      else              run_txn($urandom_range(0, 1), 16'($urandom), 16'($urandom), 1,
                                $urandom_range(16, 300));
    end
    chk("scoreboard_drained", sb.size(), 0);

    // Reset in the middle of a write with a second command held pending.
    wait_ready();
    cmd_write   = 1'b1;
    cmd_address = 16'h0BAD;
    cmd_data    = 16'hBEEF;
    cmd_valid   = 1'b1;
    a = cyc;
    while (cyc < a + 10) @(negedge clk);
    chk("busy_before_reset", cmd_ready, 0);
    chk("iow_low_before_reset", iow, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_iow", iow, 1);
    chk("post_reset_data_write", data_write, 1);
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_address_HPS", address_HPS, 0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_after_reset", busy, 0);
    chk("no_pending_rsp", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
